pos_mask_assembler: RTL and testbench

//   Inverse of the leading-one position encoder. Accepts a stream of bit-position codes and

---
 rtl/pos_mask_assembler_pkg.sv | 27 ++
 rtl/pos_mask_assembler.sv | 149 ++++++++++++++
 tb/tb_pos_mask_assembler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pos_mask_assembler_pkg.sv
// Shared definitions for the position-code mask assembler and its neighbours.
//   MASK_W    : default width of the reassembled word
//   CODE_W    : default width of a position code (must be able to hold MASK_W)
//   POS_NONE  : the "no bit" code, equal to MASK_W
//   ST_ACCUM / ST_HOLD : assembler state encodings
//   pos_to_onehot : position code -> one-hot word, position 0 = MSB
package pos_mask_assembler_pkg;

  localparam int unsigned MASK_W = 32;
  localparam int unsigned CODE_W = $clog2(MASK_W) + 1;

  localparam logic [CODE_W-1:0] POS_NONE = CODE_W'(MASK_W);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Codes >= MASK_W map to an all-zero word.
  function automatic logic [MASK_W-1:0] pos_to_onehot(input logic [CODE_W-1:0] pos);
    logic [MASK_W-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      oh[i] = (pos == CODE_W'(MASK_W - 1 - i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/pos_mask_assembler.sv
// Rebuilds a WIDTH-bit word from a stream of bit-position codes (position 0 = MSB,
// code WIDTH = no bit). One word is emitted per pos_last beat, then held until taken.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pos_in/pos_valid/pos_last/pos_ready : input beat stream
//   word_out/word_cnt/err_dup/err_range : assembled word, distinct-bit count, error flags
//   word_valid/word_ready                 : output handshake
module pos_mask_assembler
  import pos_mask_assembler_pkg::*;
#(
  parameter int unsigned WIDTH = MASK_W,
  parameter int unsigned POS_W = CODE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] pos_in,
  input  logic             pos_valid,
  input  logic             pos_last,
  output logic             pos_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [POS_W-1:0] word_cnt,
  output logic             err_dup,
  output logic             err_range
);

  localparam logic [POS_W-1:0] CODE_NONE = POS_W'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic             dup_q, dup_d;
  logic             rng_q, rng_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [POS_W-1:0] wcnt_q, wcnt_d;
  logic             wdup_q, wdup_d;
  logic             wrng_q, wrng_d;
  logic             wvalid_q, wvalid_d;

  logic [WIDTH-1:0] hit;
  logic             in_range, over_range, already, beat;
  logic [WIDTH-1:0] acc_upd;
  logic [POS_W-1:0] cnt_upd;
  logic             dup_upd, rng_upd;

  // Decode the incoming code to the MSB-first bit it addresses.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hit[i] = (pos_in == POS_W'(WIDTH - 1 - i));
    end
  end

  // Accumulator contents as they would be after absorbing the current beat.
  always_comb begin
    in_range   = (pos_in < CODE_NONE);
    over_range = (pos_in > CODE_NONE);
    already    = |(acc_q & hit);
    acc_upd    = acc_q | hit;
    cnt_upd    = (in_range && !already) ? cnt_q + POS_W'(1) : cnt_q;
    dup_upd    = dup_q | (in_range & already);
    rng_upd    = rng_q | over_range;
  end

  assign beat = pos_valid & pos_ready;

  // Next-state and register-input logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dup_d    = dup_q;
    rng_d    = rng_q;
    word_d   = word_q;
    wcnt_d   = wcnt_q;
    wdup_d   = wdup_q;
    wrng_d   = wrng_q;
    wvalid_d = wvalid_q;

    case (state_q)
      ST_ACCUM: begin
        if (beat) begin
          if (pos_last) begin
            word_d   = acc_upd;
            wcnt_d   = cnt_upd;
            wdup_d   = dup_upd;
            wrng_d   = rng_upd;
            wvalid_d = 1'b1;
            state_d  = ST_HOLD;
            acc_d    = '0;
            cnt_d    = '0;
            dup_d    = 1'b0;
            rng_d    = 1'b0;
          end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
            dup_d = dup_upd;
            rng_d = rng_upd;
          end
        end
      end
      ST_HOLD: begin
        if (wvalid_q && word_ready) begin
          wvalid_d = 1'b0;
          state_d  = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      dup_q    <= 1'b0;
      rng_q    <= 1'b0;
      word_q   <= '0;
      wcnt_q   <= '0;
      wdup_q   <= 1'b0;
      wrng_q   <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dup_q    <= dup_d;
      rng_q    <= rng_d;
      word_q   <= word_d;
      wcnt_q   <= wcnt_d;
      wdup_q   <= wdup_d;
      wrng_q   <= wrng_d;
      wvalid_q <= wvalid_d;
    end
  end

  // Ready depends only on the state register, never on word_ready.
  assign pos_ready  = (state_q == ST_ACCUM);
  assign word_out   = word_q;
  assign word_cnt   = wcnt_q;
  assign err_dup    = wdup_q;
  assign err_range  = wrng_q;
  assign word_valid = wvalid_q;

endmodule

// File: tb/tb_pos_mask_assembler.sv
// Self-checking bench for pos_mask_assembler: directed scenarios plus randomized
// words checked against a behavioural model of the position-to-mask rules.
module tb_pos_mask_assembler;
  import pos_mask_assembler_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  pos_in;
  logic        pos_valid;
  logic        pos_last;
  logic        pos_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [5:0]  word_cnt;
  logic        err_dup;
  logic        err_range;

  int checks = 0;
  int fails  = 0;

  int          cur_codes[$];
  logic [31:0] exp_word;
  int          exp_cnt;
  logic        exp_dup;
  logic        exp_rng;

  pos_mask_assembler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pos_in     (pos_in),
    .pos_valid  (pos_valid),
    .pos_last   (pos_last),
    .pos_ready  (pos_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_cnt   (word_cnt),
    .err_dup    (err_dup),
    .err_range  (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference: a set of seen positions; word = those positions read MSB-first.
  task automatic model_word();
    bit seen[32];
    exp_word = '0;
    exp_cnt  = 0;
    exp_dup  = 1'b0;
    exp_rng  = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (cur_codes[k]) begin
      if (cur_codes[k] < 32) begin
        if (seen[cur_codes[k]]) exp_dup = 1'b1;
        seen[cur_codes[k]] = 1'b1;
      end else if (cur_codes[k] > 32) begin
        exp_rng = 1'b1;
      end
    end
    for (int p = 0; p < 32; p++) begin
      if (seen[p]) begin
        exp_word = exp_word + (32'd1 << (31 - p));
        exp_cnt++;
      end
    end
  endtask

  // Present one beat at a negedge and return at the negedge after it was taken.
  task automatic send_beat(input int code, input logic last);
    int n;
    pos_valid = 1'b1;
    pos_in    = 6'(code);
    pos_last  = last;
    n = 0;
    while (!pos_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pos_ready) begin
      checks++;
      fails++;
      $display("FAIL beat_accept_timeout: pos_ready=%0b expected 1", pos_ready);
    end
    @(negedge clk);
  endtask

  // Stream cur_codes as one word, check the result, hold it hold_cycles, then take it.
  task automatic run_word(input string name, input int hold_cycles);
    logic [31:0] held;
    model_word();
    foreach (cur_codes[k]) send_beat(cur_codes[k], k == cur_codes.size() - 1);
    pos_valid = 1'b0;
    pos_last  = 1'b0;
    checks++;
    if (word_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_latency: word_valid=%0b expected 1", name, word_valid);
    end
    checks++;
    if (word_out !== exp_word) begin
      fails++;
      $display("FAIL %s_word: word_out=%h expected %h", name, word_out, exp_word);
    end
    checks++;
    if (word_cnt !== 6'(exp_cnt)) begin
      fails++;
      $display("FAIL %s_cnt: word_cnt=%0d expected %0d", name, word_cnt, exp_cnt);
    end
    checks++;
    if (err_dup !== exp_dup || err_range !== exp_rng) begin
      fails++;
      $display("FAIL %s_err: dup=%0b range=%0b expected dup=%0b range=%0b",
               name, err_dup, err_range, exp_dup, exp_rng);
    end
    held = word_out;
    for (int c = 0; c < hold_cycles; c++) begin
      pos_valid = 1'b1;
      pos_in    = 6'd0;
      @(negedge clk);
      checks++;
      if (pos_ready !== 1'b0 || word_valid !== 1'b1 || word_out !== held) begin
        fails++;
        $display("FAIL %s_hold: pos_ready=%0b valid=%0b word=%h expected 0 1 %h",
                 name, pos_ready, word_valid, word_out, held);
      end
    end
    pos_valid  = 1'b0;
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || pos_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_release: word_valid=%0b pos_ready=%0b expected 0 1",
               name, word_valid, pos_ready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pos_valid  = 1'b1;
    pos_in     = 6'd3;
    pos_last   = 1'b1;
    word_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || pos_ready !== 1'b1 || word_out !== 32'd0 ||
        word_cnt !== 6'd0 || err_dup !== 1'b0 || err_range !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%0b ready=%0b word=%h cnt=%0d dup=%0b rng=%0b expected 0 1 0 0 0 0",
               word_valid, pos_ready, word_out, word_cnt, err_dup, err_range);
    end
    pos_valid = 1'b0;
    pos_last  = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: word_valid=%0b expected 0", word_valid);
    end
  endtask

  task automatic test_basic();
    cur_codes = '{0, 31};
    run_word("basic", 0);
  endtask

  task automatic test_empty_range();
    cur_codes = '{32};
    run_word("empty", 0);
    cur_codes = '{40};
    run_word("range", 0);
    cur_codes = '{32, 9, 32};
    run_word("empty_mid", 0);
  endtask

  task automatic test_dup();
    cur_codes = '{5, 5, 7};
    run_word("dup", 0);
    cur_codes = '{0};
    run_word("dup_cleared", 0);
  endtask

  task automatic test_back_to_back();
    cur_codes = '{3, 9};
    run_word("backpressure", 4);
    cur_codes = '{12};
    run_word("b2b_next", 0);
  endtask

  task automatic test_random();
    int len;
    for (int w = 0; w < 30; w++) begin
      cur_codes.delete();
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) cur_codes.push_back($urandom_range(0, 36));
      run_word("random", $urandom_range(0, 2));
    end
    cur_codes.delete();
    for (int b = 0; b < 32; b++) cur_codes.push_back(b);
    run_word("full", 0);
  endtask

  task automatic test_round_trip();
    logic [31:0] d;
    logic [32:0] twice;
    int p;
    for (int t = 0; t < 10; t++) begin
      d = $urandom();
      if (d == 32'd0) d = 32'd1;
      p = 0;
      while (p < 32 && d[31 - p] == 1'b0) p++;
      cur_codes = '{p};
      run_word("roundtrip", 0);
      twice = {word_out, 1'b0};
      checks++;
      if (word_out == 32'd0 || (word_out & d) !== word_out || {1'b0, d} >= twice ||
          word_cnt !== 6'd1) begin
        fails++;
        $display("FAIL roundtrip_msb: word_out=%h cnt=%0d for D=%h expected its MSB with cnt 1",
                 word_out, word_cnt, d);
      end
    end
  endtask

  task automatic test_reset_midword();
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    pos_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (word_valid !== 1'b0 || pos_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_noword: word_valid=%0b pos_ready=%0b expected 0 1",
                 word_valid, pos_ready);
      end
    end
    cur_codes = '{4};
    run_word("after_mid_reset", 0);
    send_beat(6, 1'b1);
    pos_valid = 1'b0;
    pos_last  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || pos_ready !== 1'b1 || word_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_hold: word_valid=%0b pos_ready=%0b word=%h expected 0 1 0",
               word_valid, pos_ready, word_out);
    end
    cur_codes = '{POS_NONE, 30};
    run_word("after_hold_reset", 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pos_valid  = 1'b0;
    pos_in     = '0;
    pos_last   = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_empty_range();
    test_dup();
    test_back_to_back();
    test_random();
    test_round_trip();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
